// File: rtl/gf180mcu_fd_sc_mcu9t5v0__chain_reader.sv
// Serial readback of a falling-edge flop bank: capture the parallel word, shift it out LSB-first over valid/ready.
// Optional trailing even-parity bit when GF180MCU_CHAIN_READER_PARITY_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__chain_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             cap,
    input  logic             srdy,
    output logic             so,
    output logic             sov,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef GF180MCU_CHAIN_READER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2,
        PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   count_q;
    logic               capture;
    logic               xfer;
    logic               last_bit;

    assign capture  = (state_q == IDLE) && cap;
    assign xfer     = sov && srdy;
    assign last_bit = (count_q == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cap) state_d = SHIFT;
`ifdef GF180MCU_CHAIN_READER_PARITY_EN
            SHIFT: if (srdy && last_bit) state_d = PAR;
            PAR:   if (srdy) state_d = FIN;
`else
            SHIFT: if (srdy && last_bit) state_d = FIN;
`endif
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (capture) begin
            shreg_q <= d;
            count_q <= '0;
        end else if ((state_q == SHIFT) && srdy) begin
            shreg_q <= shreg_q >> 1;
            count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef GF180MCU_CHAIN_READER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (capture) begin
            parity_q <= ^d;
        end
    end
`endif

    // Outputs decode only registered state, so nothing combinational reaches them from the inputs.
    always_comb begin
        so   = 1'b0;
        sov  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT: begin
                so   = shreg_q[0];
                sov  = 1'b1;
                busy = 1'b1;
            end
`ifdef GF180MCU_CHAIN_READER_PARITY_EN
            PAR: begin
                so   = parity_q;
                sov  = 1'b1;
                busy = 1'b1;
            end
`endif
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_done_not_valid : assert property (@(posedge clk) disable iff (rst) done |-> !sov);
    a_valid_is_busy  : assert property (@(posedge clk) disable iff (rst) sov |-> busy);
    a_xfer_in_range  : assert property (@(posedge clk) disable iff (rst)
                                        (xfer && state_q == SHIFT) |-> (count_q < CNT_W'(WIDTH)));
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__chain_reader.sv
// Directed bench for the chain reader: reset, basic shift, backpressure, capture isolation, mid-word reset, parity.
module tb_gf180mcu_fd_sc_mcu9t5v0__chain_reader;

    localparam int WIDTH = 8;
`ifdef GF180MCU_CHAIN_READER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic             cap;
    logic             srdy;
    logic             so;
    logic             sov;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    gf180mcu_fd_sc_mcu9t5v0__chain_reader #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .cap  (cap),
        .srdy (srdy),
        .so   (so),
        .sov  (sov),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Runs one word from the negedge before (do_cap) or after (!do_cap) the capture edge.
    task automatic run_word(input string tag, input logic [WIDTH-1:0] data, input bit do_cap,
                            input int stall_a, input int stall_b, input int stall_len,
                            input bit mutate_d, input bit cap_mid);
        int  bits        = 0;
        int  busy_cycles = 0;
        int  done_cnt    = 0;
        int  done_bits   = -1;
        int  stall_rem   = 0;
        int  last_stall  = -1;
        int  n_stalls    = 0;
        bit  cap_done    = 1'b0;
        bit  finished    = 1'b0;
        logic exp_bit;
        if (do_cap) begin
            d   = data;
            cap = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            cap = cap_mid && (bits == 4) && !cap_done;
            if (cap) cap_done = 1'b1;
            if (mutate_d && cyc == 0) d = 8'hFF;
            if (stall_rem == 0 && sov && bits != last_stall && (bits == stall_a || bits == stall_b)) begin
                stall_rem  = stall_len;
                last_stall = bits;
                n_stalls++;
            end
            srdy = (stall_rem == 0);
            if (stall_rem > 0) stall_rem--;
            exp_bit = (bits < WIDTH) ? data[bits] : ^data;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            busy_cycles++;
            if (done) begin
                done_cnt++;
                done_bits = bits;
            end
            if (sov && !srdy) begin
                check({tag, "_hold_sov"}, sov, 1'b1);
                check({tag, "_hold_so"}, so, exp_bit);
            end
            if (sov && srdy) begin
                check($sformatf("%s_bit%0d", tag, bits), so, exp_bit);
                bits++;
            end
            @(negedge clk);
        end
        cap  = 1'b0;
        srdy = 1'b1;
        check({tag, "_timeout"}, finished, 1'b1);
        check({tag, "_nbits"}, bits, WIDTH + PB);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_done_after_last"}, done_bits, WIDTH + PB);
        check({tag, "_busy_cycles"}, busy_cycles, WIDTH + PB + 1 + n_stalls * stall_len);
    endtask

    initial begin
        int sov_seen;
        rst  = 1'b1;
        d    = 8'hA5;
        cap  = 1'b1;
        srdy = 1'b1;

        // Reset held with CAP high: outputs must stay quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d", i), {so, sov, busy, done}, 4'b0000);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_first_cap_sov", sov, 1'b1);
        check("rst_first_cap_busy", busy, 1'b1);
        run_word("rst_word", 8'hA5, 1'b0, -1, -1, 0, 1'b0, 1'b0);

        // Basic word, SRDY tied high: 1,0,1,0,0,1,0,1.
        run_word("basic", 8'hA5, 1'b1, -1, -1, 0, 1'b0, 1'b0);

        // Backpressure: 3-cycle stalls before transfers 2 and 5.
        run_word("bp", 8'h3C, 1'b1, 2, 5, 3, 1'b0, 1'b0);

        // D changes after capture and CAP pulses mid-word: neither may leak in.
        run_word("iso", 8'h00, 1'b1, -1, -1, 0, 1'b1, 1'b1);
        sov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (sov || busy) sov_seen++;
            @(negedge clk);
        end
        check("iso_no_second_word", sov_seen, 0);

        // Reset after three transfers of 8'hF0.
        d   = 8'hF0;
        cap = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cap  = 1'b0;
        srdy = 1'b1;
        check("rstmid_bit0", so, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_async_sov", sov, 1'b0);
        check("rstmid_async_busy", busy, 1'b0);
        sov_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || sov) sov_seen++;
        end
        check("rstmid_no_done", sov_seen, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_idle_after", {sov, busy, done}, 3'b000);
        run_word("rstmid_new", 8'h01, 1'b1, -1, -1, 0, 1'b0, 1'b0);

`ifdef GF180MCU_CHAIN_READER_PARITY_EN
        // Odd weight gives parity 1, even weight gives 0; last bit checked inside run_word.
        run_word("par07", 8'h07, 1'b1, -1, -1, 0, 1'b0, 1'b0);
        run_word("par03", 8'h03, 1'b1, 3, -1, 2, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
